// File: rtl/mips_datapath_pkg.sv
// Shared definitions for the single-cycle MIPS datapath: ALU operation
// encodings, primary opcodes, register-file geometry and reset PC default.
package mips_datapath_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam int NREGS = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sign-extend a 16-bit immediate to a full word.
  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_datapath_if.sv
// Bus bundle between the controller/memories (master) and the datapath
// (slave). There is no handshake: every signal is a plain level that is
// valid for the whole clock cycle. The master holds controls, instr and
// readdata stable through the rising edge; the slave's outputs are pure
// combinational functions of those levels plus the current PC/registers.
interface mips_datapath_if;
  import mips_datapath_pkg::*;

  logic        memtoreg;
  logic        pcsrc;
  logic        alusrc;
  logic        regdst;
  logic        regwrite;
  logic        jump;
  logic [2:0]  alucontrol;
  logic [31:0] instr;
  logic [31:0] readdata;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;

  modport master (
    output memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol,
    output instr, readdata,
    input  pc, aluout, writedata, op, funct, zero
  );

  modport slave (
    input  memtoreg, pcsrc, alusrc, regdst, regwrite, jump, alucontrol,
    input  instr, readdata,
    output pc, aluout, writedata, op, funct, zero
  );

endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, synchronous reset, r0 hardwired to zero. Reads return the value held
// before the current edge; a same-cycle write becomes visible next cycle.
module mips_regfile
  import mips_datapath_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we3,
  input  logic [4:0]  wa3,
  input  logic [31:0] wd3
);

  logic [31:0] regs [NREGS];

  // Clear everything on reset; otherwise commit one write, never to r0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we3 && (wa3 != 5'd0)) begin
      regs[wa3] <= wd3;
    end
  end

  // Combinational reads with r0 forced to zero.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
  end

endmodule

// File: rtl/mips_datapath.sv
// Single-cycle MIPS datapath: PC register, next-PC selection (jump, branch,
// sequential), sign extension, ALU and writeback muxing around the register
// file. Decoded controls come in from the controller; op/funct/zero go back.
module mips_datapath
  import mips_datapath_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           reset,
  mips_datapath_if.slave dp
);

  logic [31:0] pc_q;
  logic [31:0] pcplus4;
  logic [31:0] pcbranch;
  logic [31:0] pcjump;
  logic [31:0] pcnext;
  logic [31:0] signimm;
  logic [31:0] srca;
  logic [31:0] rtval;
  logic [31:0] srcb;
  logic [31:0] aluresult;
  logic [31:0] result;
  logic [4:0]  writereg;

  // PC register; reset restarts execution at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pcnext;
    end
  end

  // Next-PC candidates and selection: jump beats branch beats sequential.
  // pc + 4 wraps silently at the top of the address space.
  always_comb begin
    signimm  = sign_extend16(dp.instr[15:0]);
    pcplus4  = pc_q + 32'd4;
    pcbranch = pcplus4 + {signimm[29:0], 2'b00};
    pcjump   = {pcplus4[31:28], dp.instr[25:0], 2'b00};
    pcnext   = pcplus4;
    if (dp.jump) begin
      pcnext = pcjump;
    end else if (dp.pcsrc) begin
      pcnext = pcbranch;
    end
  end

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (dp.instr[25:21]),
    .ra2   (dp.instr[20:16]),
    .rd1   (srca),
    .rd2   (rtval),
    .we3   (dp.regwrite),
    .wa3   (writereg),
    .wd3   (result)
  );

  // ALU: wrapping add/sub, bitwise ops, signed set-less-than; unused codes give 0.
  always_comb begin
    srcb      = dp.alusrc ? signimm : rtval;
    aluresult = 32'd0;
    case (dp.alucontrol)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = {31'd0, ($signed(srca) < $signed(srcb))};
      default: aluresult = 32'd0;
    endcase
  end

  // Writeback destination and data selection.
  always_comb begin
    writereg = dp.regdst ? dp.instr[15:11] : dp.instr[20:16];
    result   = dp.memtoreg ? dp.readdata : aluresult;
  end

  // Outputs back to the controller and the memories.
  always_comb begin
    dp.pc        = pc_q;
    dp.aluout    = aluresult;
    dp.zero      = (aluresult == 32'd0);
    dp.writedata = rtval;
    dp.op        = dp.instr[31:26];
    dp.funct     = dp.instr[5:0];
  end

endmodule

// File: tb/tb_mips_datapath.sv
// Directed scenarios plus randomized instruction stream for mips_datapath,
// checked against an architectural model (register array + PC).
module tb_mips_datapath;
  import mips_datapath_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic       memtoreg;
    logic       pcsrc;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic [2:0] alucontrol;
  } ctl_t;

  typedef struct packed {
    logic [31:0] aluout;
    logic        zero;
    logic [31:0] writedata;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  funct;
  } obs_t;

  localparam ctl_t C_NONE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010};
  localparam ctl_t C_ADDI = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
  localparam ctl_t C_ADD  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010};
  localparam ctl_t C_SLT  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111};
  localparam ctl_t C_LW   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010};
  localparam ctl_t C_BEQ  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110};
  localparam ctl_t C_BEQJ = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110};
  localparam ctl_t C_J    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_datapath_if dp();

  mips_datapath #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp)
  );

  int errors = 0;
  int checks = 0;

  // architectural reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_alu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      3'b010: return a + b;
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  // driver: apply one instruction for one cycle, sample DUT, predict, advance model
  task automatic run_instr(input ctl_t c, input logic [31:0] ins, input logic [31:0] rdata,
                           output obs_t o, output obs_t e);
    logic [31:0] a, rt_v, simm, res, pc4, pcn;
    logic [4:0]  wr;
    @(negedge clk);
    dp.memtoreg   = c.memtoreg;
    dp.pcsrc      = c.pcsrc;
    dp.alusrc     = c.alusrc;
    dp.regdst     = c.regdst;
    dp.regwrite   = c.regwrite;
    dp.jump       = c.jump;
    dp.alucontrol = c.alucontrol;
    dp.instr      = ins;
    dp.readdata   = rdata;
    #1;
    o.aluout    = dp.aluout;
    o.zero      = dp.zero;
    o.writedata = dp.writedata;
    o.pc        = dp.pc;
    o.op        = dp.op;
    o.funct     = dp.funct;
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = m_regs[ins[25:21]];
    rt_v = m_regs[ins[20:16]];
    res  = m_alu(c.alucontrol, a, c.alusrc ? simm : rt_v);
    e.aluout    = res;
    e.zero      = (res == 32'd0);
    e.writedata = rt_v;
    e.pc        = m_pc;
    e.op        = ins[31:26];
    e.funct     = ins[5:0];
    pc4 = m_pc + 32'd4;
    if (c.jump)       pcn = {pc4[31:28], ins[25:0], 2'b00};
    else if (c.pcsrc) pcn = pc4 + simm * 32'd4;
    else              pcn = pc4;
    wr = c.regdst ? ins[15:11] : ins[20:16];
    @(posedge clk);
    if (reset) begin
      m_pc = RST_PC;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      m_pc = pcn;
      if (c.regwrite && wr != 5'd0) m_regs[wr] = c.memtoreg ? rdata : res;
    end
    #1;
  endtask

  // driver: read register r through the rt port (store-data bus)
  task automatic get_reg(input int r, output logic [31:0] v);
    obs_t o, e;
    run_instr(C_NONE, i_type(OP_SW, 5'd0, r[4:0], 16'd0), 32'd0, o, e);
    v = o.writedata;
  endtask

  task automatic test_reset();
    obs_t o, e;
    logic [31:0] v;
    reset = 1'b1;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd3, 16'h1234), 32'd0, o, e);
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd4, 16'h4321), 32'd0, o, e);
    checks++;
    if (dp.pc !== RST_PC) begin
      errors++; $display("FAIL reset_pc actual=%h required=%h", dp.pc, RST_PC);
    end
    reset = 1'b0;
    get_reg(0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL reset_r0 actual=%h required=0", v); end
    checks++;
    if (dp.pc !== RST_PC + 32'd4) begin
      errors++; $display("FAIL reset_release_pc actual=%h required=%h", dp.pc, RST_PC + 32'd4);
    end
    for (int r = 1; r < 32; r++) begin
      get_reg(r, v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_r%0d actual=%h required=0", r, v); end
    end
  endtask

  task automatic test_rtype_add();
    obs_t o, e;
    logic [31:0] v;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd1, 16'd5), 32'd0, o, e);
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd2, 16'd7), 32'd0, o, e);
    run_instr(C_ADD, r_type(5'd1, 5'd2, 5'd3, 6'h20), 32'd0, o, e);
    checks++;
    if (o.aluout !== 32'd12) begin errors++; $display("FAIL add_aluout actual=%h required=%h", o.aluout, 32'd12); end
    checks++;
    if (o.funct !== 6'h20 || o.op !== OP_RTYPE) begin
      errors++; $display("FAIL add_opfunct actual=%h/%h required=%h/%h", o.op, o.funct, OP_RTYPE, 6'h20);
    end
    get_reg(3, v);
    checks++;
    if (v !== 32'd12) begin errors++; $display("FAIL add_r3 actual=%h required=%h", v, 32'd12); end
  endtask

  task automatic test_branch();
    obs_t o, e;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd2, 16'd5), 32'd0, o, e);   // r2 = r1 = 5
    run_instr(C_J, {OP_J, 26'd8}, 32'd0, o, e);                           // pc -> 0x20
    run_instr(C_BEQ, i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 32'd0, o, e);
    checks++;
    if (o.pc !== 32'h20) begin errors++; $display("FAIL beq_pc_at actual=%h required=%h", o.pc, 32'h20); end
    checks++;
    if (o.zero !== 1'b1) begin errors++; $display("FAIL beq_zero actual=%b required=1", o.zero); end
    checks++;
    if (dp.pc !== 32'h1C) begin errors++; $display("FAIL beq_target actual=%h required=%h", dp.pc, 32'h1C); end
    run_instr(C_J, {OP_J, 26'd8}, 32'd0, o, e);                           // back to 0x20
    run_instr(C_BEQJ, i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 32'd0, o, e);
    checks++;
    if (dp.pc !== 32'h008B_FFF8) begin
      errors++; $display("FAIL jump_over_branch actual=%h required=%h", dp.pc, 32'h008B_FFF8);
    end
  endtask

  task automatic test_jump_wrap();
    obs_t o, e;
    run_instr(C_J, {OP_J, 26'd0}, 32'd0, o, e);                           // pc -> 0
    run_instr(C_BEQ, i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFFE), 32'd0, o, e);  // 4 - 8
    checks++;
    if (dp.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch_back actual=%h required=%h", dp.pc, 32'hFFFF_FFFC); end
    run_instr(C_NONE, i_type(OP_SW, 5'd0, 5'd0, 16'd0), 32'd0, o, e);
    checks++;
    if (dp.pc !== 32'h0) begin errors++; $display("FAIL pc_wrap actual=%h required=0", dp.pc); end
    run_instr(C_BEQ, i_type(OP_BEQ, 5'd1, 5'd2, 16'hFFFD), 32'd0, o, e);  // 4 - 12
    run_instr(C_J, {OP_J, 26'd4}, 32'd0, o, e);                           // region F
    checks++;
    if (dp.pc !== 32'hF000_0010) begin errors++; $display("FAIL jump_region actual=%h required=%h", dp.pc, 32'hF000_0010); end
    run_instr(C_J, {OP_J, 26'h100}, 32'd0, o, e);
    checks++;
    if (dp.pc !== 32'hF000_0400) begin errors++; $display("FAIL jump_target actual=%h required=%h", dp.pc, 32'hF000_0400); end
  endtask

  task automatic test_r0_slt_lw();
    obs_t o, e;
    logic [31:0] v;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd0, 16'd9), 32'd0, o, e);
    checks++;
    if (o.aluout !== 32'd9) begin errors++; $display("FAIL addi_r0_alu actual=%h required=%h", o.aluout, 32'd9); end
    get_reg(0, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL r0_write actual=%h required=0", v); end
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd1, 16'hFFFF), 32'd0, o, e);
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd2, 16'd1), 32'd0, o, e);
    run_instr(C_SLT, r_type(5'd1, 5'd2, 5'd4, 6'h2A), 32'd0, o, e);
    checks++;
    if (o.aluout !== 32'd1) begin errors++; $display("FAIL slt_alu actual=%h required=1", o.aluout); end
    get_reg(4, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("FAIL slt_r4 actual=%h required=1", v); end
    run_instr(C_LW, i_type(OP_LW, 5'd0, 5'd6, 16'h0010), 32'hDEAD_BEEF, o, e);
    checks++;
    if (o.aluout !== 32'h10) begin errors++; $display("FAIL lw_addr actual=%h required=%h", o.aluout, 32'h10); end
    get_reg(6, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_r6 actual=%h required=%h", v, 32'hDEAD_BEEF); end
    // same-cycle read of the register being written returns the old value
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd1, 5'd1, 16'd1), 32'd0, o, e);
    checks++;
    if (o.writedata !== 32'hFFFF_FFFF || o.aluout !== 32'd0) begin
      errors++; $display("FAIL old_value actual=%h/%h required=%h/%h", o.writedata, o.aluout, 32'hFFFF_FFFF, 32'd0);
    end
    get_reg(1, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL new_value actual=%h required=0", v); end
  endtask

  task automatic test_reset_midop();
    obs_t o, e;
    logic [31:0] v;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd5, 16'h55), 32'd0, o, e);
    reset = 1'b1;
    run_instr(C_ADDI, i_type(OP_ADDI, 5'd0, 5'd5, 16'h77), 32'd0, o, e);
    reset = 1'b0;
    checks++;
    if (dp.pc !== RST_PC) begin errors++; $display("FAIL midop_pc actual=%h required=%h", dp.pc, RST_PC); end
    get_reg(5, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL midop_r5 actual=%h required=0", v); end
  endtask

  task automatic test_random();
    obs_t o, e;
    ctl_t c;
    logic [31:0] v;
    for (int n = 0; n < 400; n++) begin
      c = ctl_t'($urandom_range(0, 511));
      if ($urandom_range(0, 7) != 0) c.jump = 1'b0;
      run_instr(c, $urandom, $urandom, o, e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_%0d actual alu=%h z=%b wd=%h pc=%h required alu=%h z=%b wd=%h pc=%h",
                 n, o.aluout, o.zero, o.writedata, o.pc, e.aluout, e.zero, e.writedata, e.pc);
      end
    end
    for (int r = 0; r < 32; r++) begin
      get_reg(r, v);
      checks++;
      if (v !== m_regs[r]) begin errors++; $display("FAIL rand_reg_r%0d actual=%h required=%h", r, v, m_regs[r]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc = RST_PC;
    dp.memtoreg = 1'b0; dp.pcsrc = 1'b0; dp.alusrc = 1'b0; dp.regdst = 1'b0;
    dp.regwrite = 1'b0; dp.jump = 1'b0; dp.alucontrol = 3'b000;
    dp.instr = 32'd0; dp.readdata = 32'd0;
    test_reset();
    test_rtype_add();
    test_branch();
    test_jump_wrap();
    test_r0_slt_lw();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
